holy_instr_encoder: RTL and testbench
=====================================

# holy_instr_encoder

RV32I instruction encoder: the inverse of the core's decoder. Accepts decoded instruction fields (opcode, registers, funct3/funct7, full-width immediate) over a valid/ready stream. Packs them into 32-bit instruction words using the core's opcode and funct encodings, then emits them through a 2-entry output buffer. It sits in front of the core's fetch/debug injection path and is also used by verification to generate instruction streams.

## Interface
- COUNT_WIDTH, 16, width of the emitted-instruction counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  7  RV32I opcode
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7; used for R-type and I-type shifts only
- in_imm  in  32  immediate as a signed byte offset or value; U-type supplies the full value with the low 12 bits ignored
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_illegal  out  1  flag qualified by out_valid
- count  out  COUNT_WIDTH  number of words emitted, wraps modulo 2^COUNT_WIDTH

## Operation
- Encoding is combinational on the in_* fields. The result word and illegal flag are written into a 2-entry FIFO on each in_valid && in_ready.
- Formats:
  - R (0110011): funct7|rs2|rs1|f3|rd|op.
  - I ALU (0010011): imm[11:0]|rs1|f3|rd|op. When f3=001 or 101, the word is funct7|imm[4:0]|rs1|f3|rd|op.
  - LOAD (0000011): I format.
  - JALR (1100111): I format with f3 forced to 000.
  - S (0100011): imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B (1100011): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - LUI (0110111) / AUIPC (0010111): imm[31:12]|rd|op.
  - JAL (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Illegal is set for any of:
  - an opcode outside the nine above;
  - B or J with imm[0]=1;
  - I ALU shift with funct7 not 0000000 or 0100000, or with funct7=0100000 and f3=001.
- An illegal bundle is stored as 32'h00000013 (addi x0,x0,0) with out_illegal=1.
- The immediate range is not checked; bits outside the format's field are dropped.
- count increments by 1 on each out_valid && out_ready.

## Timing
- Reset values: out_valid=0, out_instr=0, out_illegal=0, count=0, FIFO empty, in_ready=1 in the cycle after reset.
- Reset asserted mid-stream discards all buffered words. No handshake completes in a cycle where rst=1.
- Latency: a bundle accepted in cycle N, with the FIFO empty, appears at out_instr with out_valid=1 in cycle N+1.
- in_ready = (occupancy < 2), derived only from registered occupancy. There is no combinational path from out_ready to in_ready.
  - When full, in_ready=0 even if out_ready=1 that cycle. in_ready returns to 1 the next cycle.
- Simultaneous push and pop at occupancy 1: occupancy stays 1. The head advances to the new word in order.
- Push with occupancy 0 and out_ready=1: the word is not visible in the same cycle.
- Order is strictly FIFO; no reordering or dropping.
- out_instr and out_illegal hold stable while out_valid=1 and out_ready=0.
- count wraps from 2^COUNT_WIDTH-1 to 0.

## Test plan
- Format encodings, one per cycle, out_ready=1 → in order:
  - addi x1,x0,5 (op 0010011, rd1, rs1 0, f3 0, imm 5) → 0x00500093;
  - add x3,x1,x2 → 0x002081B3;
  - sw x2,8(x1) → 0x0020A423;
  - beq x1,x2,imm -4 → 0xFE208EE3;
  - jal x1,imm 8 → 0x008000EF;
  - lui x5,imm 0x12345000 → 0x123452B7.
  - Each appears one cycle after acceptance, and count=6 at the end.
- srai x1,x1,3 (f3 101, funct7 0100000, imm 3) → 0x4030D093, out_illegal=0. Same bundle with funct7 0000001 → 0x00000013, out_illegal=1.
- Opcode 1111111, and B with imm 3 → 0x00000013, out_illegal=1 for each. count still increments on emission.
- Backpressure with out_ready=0 and three bundles offered:
  - the first two are accepted; in_ready=0 from the cycle after the second acceptance;
  - the head stays stable;
  - out_ready=1 then drains both in order, and the third is accepted the cycle after a pop.
- Assert rst with 2 words buffered → next cycle out_valid=0, count=0, in_ready=1, and no stale words emitted.
- COUNT_WIDTH=4, 17 emissions → count reads 1.

Source files
------------

// File: rtl/holy_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into 32-bit words
// and streams them out through a 2-entry FIFO.
module holy_instr_encoder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [31:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic                   out_illegal,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [32:0]            r_mem [2];
  logic                   r_wp;
  logic                   r_rp;
  logic [1:0]             r_occ;
  logic [COUNT_WIDTH-1:0] r_count;

  logic        w_r, w_alu, w_ld, w_jalr, w_s;
  logic        w_b, w_u, w_j, w_sh, w_sh_bad;
  logic [31:0] w_word;
  logic        w_ill;
  logic        w_push;
  logic        w_pop;

  assign w_r    = in_opcode == 7'b0110011;
  assign w_alu  = in_opcode == 7'b0010011;
  assign w_ld   = in_opcode == 7'b0000011;
  assign w_jalr = in_opcode == 7'b1100111;
  assign w_s    = in_opcode == 7'b0100011;
  assign w_b    = in_opcode == 7'b1100011;
  assign w_u    = (in_opcode == 7'b0110111) ||
                  (in_opcode == 7'b0010111);
  assign w_j    = in_opcode == 7'b1101111;

  assign w_sh = (in_funct3 == 3'b001) ||
                (in_funct3 == 3'b101);
  // slli only takes funct7=0; srli/srai take 0 or 0100000
  assign w_sh_bad =
    ((in_funct7 != 7'b0000000) &&
     (in_funct7 != 7'b0100000)) ||
    ((in_funct7 == 7'b0100000) &&
     (in_funct3 == 3'b001));

  always_comb begin
    w_word = '0;
    w_ill  = 1'b0;
    unique case (1'b1)
      w_r:
        w_word = {in_funct7, in_rs2, in_rs1,
                  in_funct3, in_rd, in_opcode};
      w_alu: begin
        if (w_sh) begin
          w_word = {in_funct7, in_imm[4:0], in_rs1,
                    in_funct3, in_rd, in_opcode};
          w_ill  = w_sh_bad;
        end else begin
          w_word = {in_imm[11:0], in_rs1,
                    in_funct3, in_rd, in_opcode};
        end
      end
      w_ld:
        w_word = {in_imm[11:0], in_rs1,
                  in_funct3, in_rd, in_opcode};
      w_jalr:
        w_word = {in_imm[11:0], in_rs1,
                  3'b000, in_rd, in_opcode};
      w_s:
        w_word = {in_imm[11:5], in_rs2, in_rs1,
                  in_funct3, in_imm[4:0], in_opcode};
      w_b: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2,
                  in_rs1, in_funct3, in_imm[4:1],
                  in_imm[11], in_opcode};
        w_ill  = in_imm[0];
      end
      w_u:
        w_word = {in_imm[31:12], in_rd, in_opcode};
      w_j: begin
        w_word = {in_imm[20], in_imm[10:1],
                  in_imm[11], in_imm[19:12],
                  in_rd, in_opcode};
        w_ill  = in_imm[0];
      end
      default:
        w_ill = 1'b1;
    endcase
    if (w_ill) w_word = NOP;
  end

  // in_ready depends on registered occupancy only
  assign in_ready    = ~r_occ[1];
  assign out_valid   = r_occ != 2'd0;
  assign out_instr   = r_mem[r_rp][31:0];
  assign out_illegal = r_mem[r_rp][32];
  assign count       = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_occ    <= 2'd0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {w_ill, w_word};
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp    <= ~r_rp;
        r_count <= r_count + 1'b1;
      end
      r_occ <= r_occ + {1'b0, w_push}
                     - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_holy_instr_encoder.sv
// Scoreboard bench for holy_instr_encoder: directed format vectors,
// backpressure, reset flush, counter wrap and randomized traffic.
module tb_holy_instr_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic          out_illegal;
  logic [CW-1:0] count;

  holy_instr_encoder #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] q[$];
  logic [32:0] cur_exp = '0;
  int          mcount = 0;
  bit          just_rst = 1'b0;
  bit          rdone = 1'b0;

  task automatic chk(string name, logic [32:0] act,
                     logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the format table with
  // plain shift/mask arithmetic; returns {illegal, word}.
  function automatic logic [32:0] model(
    int unsigned op, int unsigned rd, int unsigned rs1,
    int unsigned rs2, int unsigned f3, int unsigned f7,
    int unsigned imm);
    int unsigned w = 0;
    bit ill = 0;
    int unsigned base = (rs1 << 15) | (rd << 7) | op;
    case (op)
      'h33: w = (f7 << 25) | (rs2 << 20) | base | (f3 << 12);
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          ill = !(f7 == 0 || f7 == 32) || (f7 == 32 && f3 == 1);
          w = (f7 << 25) | ((imm % 32) << 20) | base | (f3 << 12);
        end else
          w = ((imm & 'hfff) << 20) | base | (f3 << 12);
      end
      'h03: w = ((imm & 'hfff) << 20) | base | (f3 << 12);
      'h67: w = ((imm & 'hfff) << 20) | base;
      'h23: w = (((imm >> 5) & 'h7f) << 25) | (rs2 << 20) |
                (rs1 << 15) | (f3 << 12) | ((imm & 31) << 7) | op;
      'h63: begin
        ill = imm % 2;
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) |
            (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
            (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
      end
      'h37, 'h17: w = (imm & 'hfffff000) | (rd << 7) | op;
      'h6f: begin
        ill = imm % 2;
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hff) << 12) |
            (rd << 7) | op;
      end
      default: ill = 1;
    endcase
    if (ill) w = 'h13;
    return {ill, w};
  endfunction

  // Monitor: compare current state, then apply the handshakes
  // that the next rising edge will perform.
  always @(negedge clk) begin
    chk("out_valid", {32'b0, out_valid}, {32'b0, q.size() != 0});
    chk("in_ready", {32'b0, in_ready}, {32'b0, q.size() < 2});
    chk("count", {29'b0, count}, 33'(mcount));
    if (q.size() != 0)
      chk("head", {out_illegal, out_instr}, q[0]);
    else if (just_rst)
      chk("reset_out", {out_illegal, out_instr}, 33'b0);
    just_rst = 1'b0;
    if (rst) begin
      q.delete();
      mcount = 0;
      just_rst = 1'b1;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        mcount = (mcount + 1) % (1 << CW);
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  // Called at posedge+2; returns at posedge+2 after acceptance.
  task automatic send(int unsigned op, int unsigned rd,
                      int unsigned rs1, int unsigned rs2,
                      int unsigned f3, int unsigned f7,
                      int unsigned imm, logic [32:0] exp);
    in_opcode = 7'(op);  in_rd = 5'(rd);
    in_rs1 = 5'(rs1);    in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3);  in_funct7 = 7'(f7);
    in_imm = imm;        cur_exp = exp;
    in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #2;
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 33'd0, 33'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic rsend();
    int unsigned ops[10] = '{'h33, 'h13, 'h03, 'h67, 'h23,
                             'h63, 'h37, 'h17, 'h6f, 0};
    int unsigned op = ops[$urandom_range(0, 9)];
    int unsigned f7s[3] = '{0, 32, 0};
    int unsigned f7, rd, rs1, rs2, f3, imm;
    if (op == 0) op = $urandom_range(0, 127);
    f7s[2] = $urandom_range(0, 127);
    f7  = f7s[$urandom_range(0, 2)];
    rd  = $urandom_range(0, 31);
    rs1 = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    f3  = $urandom_range(0, 7);
    imm = $urandom;
    send(op, rd, rs1, rs2, f3, f7, imm,
         model(op, rd, rs1, rs2, f3, f7, imm));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        @(posedge clk); #2;
        return;
      end
    end
    chk("drain_timeout", 33'd0, 33'd1);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    do_reset();
    @(posedge clk); #2;

    out_ready = 1'b1;
    send('h13, 1, 0, 0, 0, 0, 5,           {1'b0, 32'h00500093});
    send('h33, 3, 1, 2, 0, 0, 0,           {1'b0, 32'h002081B3});
    send('h23, 0, 1, 2, 2, 0, 8,           {1'b0, 32'h0020A423});
    send('h63, 0, 1, 2, 0, 0, 32'hFFFFFFFC, {1'b0, 32'hFE208EE3});
    send('h6f, 1, 0, 0, 0, 0, 8,           {1'b0, 32'h008000EF});
    send('h37, 5, 0, 0, 0, 0, 32'h12345000, {1'b0, 32'h123452B7});
    drain();
    chk("count_after_6", {29'b0, count}, 33'd6);

    send('h13, 1, 1, 0, 5, 'h20, 3, {1'b0, 32'h4030D093});
    send('h13, 1, 1, 0, 5, 'h01, 3, {1'b1, 32'h00000013});
    send('h7f, 1, 2, 3, 0, 0, 0,    {1'b1, 32'h00000013});
    send('h63, 0, 1, 2, 0, 0, 3,    {1'b1, 32'h00000013});
    drain();
    chk("count_after_10", {29'b0, count}, 33'd10);

    out_ready = 1'b0;
    send('h13, 1, 0, 0, 0, 0, 1, {1'b0, 32'h00100093});
    send('h13, 2, 0, 0, 0, 0, 2, {1'b0, 32'h00200113});
    fork
      send('h13, 3, 0, 0, 0, 0, 3, {1'b0, 32'h00300193});
      begin
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send('h13, 4, 0, 0, 0, 0, 4, {1'b0, 32'h00400213});
    send('h13, 5, 0, 0, 0, 0, 5, {1'b0, 32'h00500293});
    do_reset();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", {29'b0, count}, 33'd0);
    chk("rst_valid", {32'b0, out_valid}, 33'd0);

    for (int i = 0; i < 17; i++)
      send('h33, i % 32, 1, 2, 0, 0, 0,
           model('h33, i % 32, 1, 2, 0, 0, 0));
    drain();
    chk("count_wrap_17", {29'b0, count}, 33'd1);

    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #2;
          end
          rsend();
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #2;
        end
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
